// File: rtl/regwrite_trace_fifo_pkg.sv
// Shared definitions for the register-write trace buffer: entry layout and
// field offsets used to pack and unpack a trace record {seq, pc, rd, data}.
package regwrite_trace_fifo_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int PC_W     = 32;

  localparam int DATA_LSB = 0;
  localparam int ADDR_LSB = DATA_LSB + DATA_W;
  localparam int PC_LSB   = ADDR_LSB + ADDR_W;
  localparam int SEQ_LSB  = PC_LSB + PC_W;

  // Total packed width of one trace entry for a given sequence width.
  function automatic int traceEntryWidth(input int seqW);
    return seqW + PC_W + ADDR_W + DATA_W;
  endfunction

endpackage

// File: rtl/regwrite_trace_fifo_if.sv
// Bundle of the register write-back observation port, trace control inputs
// and the valid/ready drain stream toward the host or checker.
interface regwrite_trace_fifo_if #(
  parameter int DEPTH  = 8,
  parameter int SEQ_W  = 16,
  parameter int DROP_W = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              trace_en;
  logic              trace_clear;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [31:0]       wb_data;
  logic [31:0]       wb_pc;

  logic              out_valid;
  logic              out_ready;
  logic [SEQ_W-1:0]  out_seq;
  logic [31:0]       out_pc;
  logic [4:0]        out_addr;
  logic [31:0]       out_data;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  // Tracer side: observes the CPU and sources the trace stream.
  modport master (
    input  trace_en, trace_clear, wb_en, wb_addr, wb_data, wb_pc, out_ready,
    output out_valid, out_seq, out_pc, out_addr, out_data, level, overflow, drop_count
  );

  // Environment side: CPU write port plus the consumer of trace entries.
  modport slave (
    output trace_en, trace_clear, wb_en, wb_addr, wb_data, wb_pc, out_ready,
    input  out_valid, out_seq, out_pc, out_addr, out_data, level, overflow, drop_count
  );

endinterface

// File: rtl/regwrite_trace_fifo_sync_fifo.sv
// Synchronous FIFO with show-ahead read data. Pointers carry one extra wrap
// bit so full and empty are distinguished without a separate counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_doPush;
  logic             w_doPop;

  // Flag and level derivation; a push into a full FIFO is only legal with a pop.
  always_comb begin
    o_empty  = (r_wrPtr == r_rdPtr);
    o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    o_level  = r_wrPtr - r_rdPtr;
    w_doPop  = i_pop && !o_empty;
    w_doPush = i_push && (!o_full || w_doPop);
    o_rdata  = o_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];
  end

  // Pointer advance; reset discards any queued entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + (AW+1)'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because empty masks the read data.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/regwrite_trace_fifo.sv
// Register-write trace recorder. Watches the register-file write port,
// stamps each architectural write with a sequence number and buffers it for
// a host to drain. Never back-pressures the CPU: entries that find the
// buffer full are dropped and counted, and the sequence gap exposes them.
module regwrite_trace_fifo
  import regwrite_trace_fifo_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int SEQ_W  = 16,
  parameter int DROP_W = 8,
  parameter bit LOG_R0 = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  regwrite_trace_fifo_if.master bus
);

  localparam int ENTRY_W = traceEntryWidth(SEQ_W);
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  logic [SEQ_W-1:0]   r_seq;
  logic               r_overflow;
  logic [DROP_W-1:0]  r_dropCount;

  logic               w_cap;
  logic               w_pop;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  logic [SEQ_W-1:0]   w_entrySeq;
  logic [ENTRY_W-1:0] w_entry;
  logic [ENTRY_W-1:0] w_head;
  logic [LVL_W-1:0]   w_level;

  // Capture qualification, drop decision and entry packing.
  always_comb begin
    w_cap      = bus.trace_en && bus.wb_en && (LOG_R0 || (bus.wb_addr != 5'd0));
    w_pop      = !w_empty && bus.out_ready;
    w_drop     = w_cap && w_full && !w_pop;
    w_entrySeq = bus.trace_clear ? '0 : r_seq;
    w_entry    = {w_entrySeq, bus.wb_pc, bus.wb_addr, bus.wb_data};
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_cap && !w_drop),
    .i_pop   (w_pop),
    .i_wdata (w_entry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Sequence counter: advances on every capture, dropped or not; clear restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seq <= '0;
    end else if (bus.trace_clear) begin
      r_seq <= w_cap ? SEQ_W'(1) : '0;
    end else if (w_cap) begin
      r_seq <= r_seq + SEQ_W'(1);
    end
  end

  // Sticky overflow and saturating drop count; a drop on the clear edge wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_dropCount <= '0;
    end else if (bus.trace_clear) begin
      r_overflow  <= w_drop;
      r_dropCount <= w_drop ? DROP_W'(1) : '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_dropCount != {DROP_W{1'b1}}) r_dropCount <= r_dropCount + DROP_W'(1);
    end
  end

  // Unpack the show-ahead head entry onto the drain stream.
  always_comb begin
    bus.out_valid  = !w_empty;
    bus.out_seq    = w_head[SEQ_LSB  +: SEQ_W];
    bus.out_pc     = w_head[PC_LSB   +: PC_W];
    bus.out_addr   = w_head[ADDR_LSB +: ADDR_W];
    bus.out_data   = w_head[DATA_LSB +: DATA_W];
    bus.level      = w_level;
    bus.overflow   = r_overflow;
    bus.drop_count = r_dropCount;
  end

endmodule

// File: tb/tb_regwrite_trace_fifo.sv
// Self-checking bench for regwrite_trace_fifo: a reference queue model acts
// as scoreboard, a small vector table covers the basic capture rules, and
// hand-written sequences cover overflow, saturation, clear and reset.
module tb_regwrite_trace_fifo;

  localparam int DEPTH  = 8;
  localparam int SEQ_W  = 16;
  localparam int DROP_W = 8;

  typedef struct {
    logic [15:0] seq;
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  typedef struct {
    bit          en;
    bit          wb;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    bit          rdy;
    int          expLevel;
    bit          expValid;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  regwrite_trace_fifo_if #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .DROP_W(DROP_W)) bus ();

  regwrite_trace_fifo #(
    .DEPTH  (DEPTH),
    .SEQ_W  (SEQ_W),
    .DROP_W (DROP_W),
    .LOG_R0 (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  entry_t      sbQ[$];
  logic [15:0] mSeq;
  logic        mOvf;
  int          mDrop;
  int          nChecks = 0;
  int          nPass = 0;
  vec_t        vecs[6];

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else nPass++;
  endtask

  task automatic modelReset();
    sbQ.delete();
    mSeq  = '0;
    mOvf  = 1'b0;
    mDrop = 0;
  endtask

  // Compares visible DUT state against the model; head fields against the scoreboard front.
  task automatic checkOutput();
    checkVal("level", 64'(bus.level), 64'(sbQ.size()));
    checkVal("out_valid", 64'(bus.out_valid), 64'(sbQ.size() != 0));
    checkVal("overflow", 64'(bus.overflow), 64'(mOvf));
    checkVal("drop_count", 64'(bus.drop_count), 64'(mDrop));
    if (sbQ.size() != 0) begin
      checkVal("head_seq", 64'(bus.out_seq), 64'(sbQ[0].seq));
      checkVal("head_pc", 64'(bus.out_pc), 64'(sbQ[0].pc));
      checkVal("head_addr", 64'(bus.out_addr), 64'(sbQ[0].addr));
      checkVal("head_data", 64'(bus.out_data), 64'(sbQ[0].data));
    end else begin
      checkVal("empty_fields", {bus.out_seq, bus.out_addr, bus.out_data[10:0]}, 64'd0);
      checkVal("empty_pc", 64'(bus.out_pc), 64'd0);
    end
  endtask

  // Drives one cycle of inputs, advances the model through the edge, then checks.
  task automatic applyStimulus(input bit en, input bit clr, input bit wb, input logic [4:0] addr,
                               input logic [31:0] data, input logic [31:0] pc, input bit rdy);
    bit cap, pop, drop;
    entry_t e;
    bus.trace_en    = en;
    bus.trace_clear = clr;
    bus.wb_en       = wb;
    bus.wb_addr     = addr;
    bus.wb_data     = data;
    bus.wb_pc       = pc;
    bus.out_ready   = rdy;
    cap  = en && wb && (addr != 5'd0);
    pop  = rdy && (sbQ.size() != 0);
    drop = cap && (sbQ.size() == DEPTH) && !pop;
    e.seq = clr ? 16'd0 : mSeq;
    e.pc = pc;
    e.addr = addr;
    e.data = data;
    if (pop) void'(sbQ.pop_front());
    if (cap && !drop) sbQ.push_back(e);
    if (cap) mSeq = e.seq + 16'd1;
    else if (clr) mSeq = 16'd0;
    if (clr) begin
      mOvf  = drop;
      mDrop = drop ? 1 : 0;
    end else if (drop) begin
      mOvf = 1'b1;
      if (mDrop < 255) mDrop++;
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset(input int cycles);
    reset = 1'b1;
    bus.trace_en = 1'b0;
    bus.trace_clear = 1'b0;
    bus.wb_en = 1'b0;
    bus.out_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    checkOutput();
  endtask

  task automatic capture(input int n, input bit rdy);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, 5'(1 + (i % 31)), $urandom, 32'h1000 + 32'(4 * i), rdy);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
  endtask

  initial begin
    bus.trace_en = 1'b0;
    bus.trace_clear = 1'b0;
    bus.wb_en = 1'b0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
    bus.wb_pc = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{1'b1, 1'b1, 5'd8, 32'h5,       32'h0, 1'b0, 1, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 5'd0, 32'h77,      32'h4, 1'b0, 1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 5'd0, 32'h0,       32'h0, 1'b1, 0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 5'd3, 32'hDEAD,    32'h8, 1'b1, 1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 5'd4, 32'hBEEF,    32'hC, 1'b0, 1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 5'd0, 32'h0,       32'h0, 1'b1, 0, 1'b0};

    doReset(2);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].en, 1'b0, vecs[i].wb, vecs[i].addr, vecs[i].data, vecs[i].pc, vecs[i].rdy);
      checkVal($sformatf("vec%0d_level", i), 64'(bus.level), 64'(vecs[i].expLevel));
      checkVal($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(vecs[i].expValid));
      if (i == 0) checkVal("first_entry", {bus.out_seq, 11'd0, bus.out_addr, bus.out_data}, {16'd0, 11'd0, 5'd8, 32'd5});
      if (i == 3) checkVal("seq_after_r0", 64'(bus.out_seq), 64'd1);
    end

    doReset(1);
    capture(10, 1'b0);
    checkVal("fill_level", 64'(bus.level), 64'd8);
    checkVal("fill_overflow", 64'(bus.overflow), 64'd1);
    checkVal("fill_drops", 64'(bus.drop_count), 64'd2);
    for (int i = 0; i < DEPTH; i++) begin
      checkVal($sformatf("drain_seq%0d", i), 64'(bus.out_seq), 64'(i));
      drain(1);
    end
    capture(1, 1'b0);
    checkVal("seq_after_gap", 64'(bus.out_seq), 64'd10);

    capture(7, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd9, 32'hCAFE, 32'h2000, 1'b1);
    checkVal("full_pushpop_level", 64'(bus.level), 64'd8);
    checkVal("full_pushpop_drops", 64'(bus.drop_count), 64'd2);
    checkVal("full_pushpop_tail", 64'(sbQ[DEPTH-1].data), 64'h0000CAFE);
    drain(DEPTH);

    capture(DEPTH, 1'b0);
    capture(300, 1'b0);
    checkVal("drop_saturated", 64'(bus.drop_count), 64'd255);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    checkVal("clear_drops", 64'(bus.drop_count), 64'd0);
    checkVal("clear_overflow", 64'(bus.overflow), 64'd0);
    checkVal("clear_level", 64'(bus.level), 64'd8);
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd12, 32'h1234, 32'h3000, 1'b0);
    checkVal("clear_drop_wins", {bus.overflow, bus.drop_count}, {1'b1, 8'd1});
    drain(DEPTH);
    capture(1, 1'b0);
    checkVal("seq_after_clear", 64'(bus.out_seq), 64'd1);
    drain(1);

    capture(5, 1'b0);
    doReset(1);
    checkVal("reset_valid", 64'(bus.out_valid), 64'd0);
    capture(1, 1'b1);
    checkVal("seq_after_reset", 64'(bus.out_seq), 64'd0);
    drain(1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
